switch_debounce: RTL



---
 rtl/switch_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Synchronise and debounce a bus of slide-switch levels, with a change strobe and busy flag.
// Optional per-bit rise_o/fall_o commit strobes are enabled by defining SWITCH_DEBOUNCE_EDGE_EN.
module switch_debounce #(
  parameter int unsigned      WIDTH           = 11,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               SYNC_STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             changed_o,
  output logic             busy_o
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("switch_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("switch_debounce: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0]                  sw_q, sw_d;
  logic [CNT_W-1:0]                  cnt_q [WIDTH];
  logic [CNT_W-1:0]                  cnt_d [WIDTH];
  logic                              changed_q, changed_d;
  logic                              busy_q, busy_d;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
`endif

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Per-bit stability counter: clear on match, commit after DEBOUNCE_CYCLES mismatched edges.
  always_comb begin
    sw_d   = sw_q;
    busy_d = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      busy_d = busy_d | (cnt_d[i] != '0);
    end
    changed_d = (sw_d != sw_q);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    rise_d = sw_d & ~sw_q;
    fall_d = ~sw_d & sw_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q    <= {SYNC_STAGES{RESET_VALUE}};
      sw_q      <= RESET_VALUE;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      rise_q    <= '0;
      fall_q    <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
      sw_q      <= sw_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      rise_q    <= rise_d;
      fall_q    <= fall_d;
`endif
    end
  end

  assign sw_o      = sw_q;
  assign changed_o = changed_q;
  assign busy_o    = busy_q;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
`endif

endmodule
